// File: rtl/addr_elastic_pipe.sv
// addr_elastic_pipe: DEPTH-stage valid/ready pipeline for address bundles
// with bubble collapse, synchronous flush, global enable and occupancy count.
module addr_elastic_pipe #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_ADDR   = 1,
  parameter int DEPTH      = 2,
  localparam int AW = NUM_ADDR * ADDR_WIDTH,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          AsyncResetN,
  input  logic          CE,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_address,
  input  logic [NUM_ADDR-1:0] in_addressValid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_address,
  output logic [NUM_ADDR-1:0] out_addressValid,
  output logic [OW-1:0] occupancy
);
  logic [DEPTH-1:0]                valid_q, valid_d, move, src_v;
  logic [DEPTH-1:0][AW-1:0]        addr_q, addr_d, src_a;
  logic [DEPTH-1:0][NUM_ADDR-1:0]  av_q, av_d, src_av;
  logic out_xfer;
  // Each stage's load source: the input port for stage 0, the previous stage otherwise.
  for (genvar i = 0; i < DEPTH; i++) begin : g_src
    if (i == 0) begin : g_in
      assign src_v[i]  = in_valid;
      assign src_a[i]  = in_address;
      assign src_av[i] = in_addressValid;
    end else begin : g_stage
      assign src_v[i]  = valid_q[i-1];
      assign src_a[i]  = addr_q[i-1];
      assign src_av[i] = av_q[i-1];
    end
  end
  assign out_xfer = CE & ~flush & valid_q[DEPTH-1] & out_ready;
  // A stage moves when any stage at or after it is empty, or the output pops.
  always_comb begin
    logic acc;
    acc = out_xfer;
    move = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc = acc | ~valid_q[k];
      move[k] = acc;
    end
  end
  assign in_ready = AsyncResetN & CE & ~flush & move[0];
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    av_d    = av_q;
    if (CE && flush) valid_d = '0;
    else if (CE) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (move[k]) begin
          valid_d[k] = src_v[k];
          addr_d[k]  = src_v[k] ? src_a[k] : addr_q[k];
          av_d[k]    = src_v[k] ? src_av[k] : av_q[k];
        end
      end
    end
  end
  always_ff @(posedge CLK or negedge AsyncResetN) begin
    if (!AsyncResetN) begin
      valid_q <= '0;
      addr_q  <= '0;
      av_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      av_q    <= av_d;
    end
  end
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(valid_q[k]);
  end
  assign out_valid        = CE & valid_q[DEPTH-1];
  assign out_address      = addr_q[DEPTH-1];
  assign out_addressValid = av_q[DEPTH-1] & {NUM_ADDR{out_valid}};
endmodule

// File: tb/tb_addr_elastic_pipe.sv
// tb_addr_elastic_pipe: directed checks of handshake, bubbles, flush, enable and async reset.
module tb_addr_elastic_pipe;
  logic        CLK = 0, AsyncResetN = 0, CE = 1, flush = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [15:0] in_address = '0, out_address;
  logic [1:0]  in_addressValid = '0, out_addressValid;
  logic [1:0]  occupancy;
  int checks = 0, errors = 0;
  addr_elastic_pipe #(.ADDR_WIDTH(8), .NUM_ADDR(2), .DEPTH(2)) dut (
    .CLK(CLK), .AsyncResetN(AsyncResetN), .CE(CE), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_address(in_address),
    .in_addressValid(in_addressValid), .out_valid(out_valid), .out_ready(out_ready),
    .out_address(out_address), .out_addressValid(out_addressValid), .occupancy(occupancy)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] a, input logic [1:0] av);
    in_valid = v;
    in_address = a;
    in_addressValid = av;
    #1;
  endtask
  initial begin
    #3;
    check("rst_occ", occupancy, 0);
    check("rst_ov", out_valid, 0);
    check("rst_ir", in_ready, 0);
    check("rst_oa", out_address, 0);
    tick();
    AsyncResetN = 1;
    out_ready = 1;
    drive(1, 16'h2211, 2'b01);
    check("t1_ir", in_ready, 1);
    tick();
    drive(0, 0, 0);
    check("t1_ov0", out_valid, 0);
    check("t1_occ0", occupancy, 1);
    tick();
    check("t1_ov", out_valid, 1);
    check("t1_oa", out_address, 16'h2211);
    check("t1_oav", out_addressValid, 2'b01);
    check("t1_occ", occupancy, 1);
    tick();
    check("t1_empty", occupancy, 0);
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 16'(i * 16'h0101), 2'b11);
      check("st_ir", in_ready, 1);
      if (i >= 2) begin
        check("st_ov", out_valid, 1);
        check("st_oa", out_address, 32'((i - 2) * 16'h0101));
      end
      tick();
    end
    drive(0, 0, 0);
    check("st_empty", occupancy, 0);
    out_ready = 0;
    drive(1, 16'h0A0B, 2'b10);
    check("bp_ir_a", in_ready, 1);
    tick();
    drive(1, 16'h0C0D, 2'b11);
    check("bp_ir_b", in_ready, 1);
    check("bp_occ1", occupancy, 1);
    tick();
    drive(1, 16'h0E0F, 2'b01);
    check("bp_occ2", occupancy, 2);
    check("bp_ir_c", in_ready, 0);
    check("bp_oa", out_address, 16'h0A0B);
    tick();
    check("bp_hold_occ", occupancy, 2);
    check("bp_hold_oa", out_address, 16'h0A0B);
    check("bp_hold_oav", out_addressValid, 2'b10);
    out_ready = 1;
    #1;
    check("bp_ir_pp", in_ready, 1);
    tick();
    drive(0, 0, 0);
    check("bp_oa_b", out_address, 16'h0C0D);
    check("bp_oav_b", out_addressValid, 2'b11);
    check("bp_occ_pp", occupancy, 2);
    tick();
    check("bp_oa_c", out_address, 16'h0E0F);
    check("bp_oav_c", out_addressValid, 2'b01);
    check("bp_occ_c", occupancy, 1);
    tick();
    check("bp_empty", occupancy, 0);
    out_ready = 0;
    drive(1, 16'h1111, 2'b11);
    tick();
    drive(1, 16'h2222, 2'b11);
    tick();
    check("fl_occ2", occupancy, 2);
    flush = 1;
    out_ready = 1;
    drive(1, 16'h3333, 2'b11);
    check("fl_ir", in_ready, 0);
    tick();
    flush = 0;
    out_ready = 0;
    drive(0, 0, 0);
    check("fl_occ", occupancy, 0);
    check("fl_ov", out_valid, 0);
    check("fl_oav", out_addressValid, 0);
    check("fl_data_kept", out_address, 16'h1111);
    drive(1, 16'h4455, 2'b11);
    tick();
    drive(0, 0, 0);
    tick();
    check("ce_occ_pre", occupancy, 1);
    CE = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h9999, 2'b11);
      check("ce_ov", out_valid, 0);
      check("ce_ir", in_ready, 0);
      check("ce_oav", out_addressValid, 0);
      tick();
      check("ce_occ", occupancy, 1);
    end
    drive(0, 0, 0);
    CE = 1;
    #1;
    check("ce_ov_on", out_valid, 1);
    check("ce_oa", out_address, 16'h4455);
    check("ce_oav_on", out_addressValid, 2'b11);
    tick();
    check("ce_empty", occupancy, 0);
    out_ready = 0;
    drive(1, 16'h5566, 2'b11);
    tick();
    drive(1, 16'h7788, 2'b01);
    tick();
    drive(0, 0, 0);
    check("ar_occ2", occupancy, 2);
    #1;
    AsyncResetN = 0;
    #1;
    check("ar_occ", occupancy, 0);
    check("ar_ov", out_valid, 0);
    check("ar_oav", out_addressValid, 0);
    check("ar_oa", out_address, 0);
    check("ar_ir", in_ready, 0);
    tick();
    AsyncResetN = 1;
    out_ready = 1;
    drive(1, 16'hBEEF, 2'b10);
    check("ar_ir_post", in_ready, 1);
    tick();
    drive(0, 0, 0);
    tick();
    check("ar_ov_post", out_valid, 1);
    check("ar_oa_post", out_address, 16'hBEEF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_elastic_pipe.md
# addr_elastic_pipe

Parametrised elastic pipeline for address-request bundles: NUM_ADDR address channels, a per-channel addressValid flag and a bundle-level valid. The block replaces the single flat clock-enabled bundle register with a DEPTH-stage pipeline that carries a valid/ready handshake, collapses bubbles, supports a synchronous flush and reports its occupancy. It sits between an address generator and a memory/port arbiter that may apply backpressure.

## Interface
- ADDR_WIDTH, 8, bits per address channel (>=1)
- NUM_ADDR, 1, number of address channels (>=1)
- DEPTH, 2, pipeline stages (>=1)
- CLK  in  1  clock, rising edge
- AsyncResetN  in  1  asynchronous, active-low reset
- CE  in  1  global enable; 0 freezes all state
- flush  in  1  synchronous clear of all stage valids
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_address  in  NUM_ADDR*ADDR_WIDTH  channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- in_addressValid  in  NUM_ADDR  per-channel valid, bit i for channel i
- out_valid  out  1  stage DEPTH-1 holds a bundle
- out_ready  in  1  downstream accepts
- out_address  out  NUM_ADDR*ADDR_WIDTH  same packing as input
- out_addressValid  out  NUM_ADDR  per-channel valid, gated by out_valid
- occupancy  out  clog2(DEPTH+1)  number of valid stages

## Operation
- Stages 0..DEPTH-1; stage 0 fed from input, stage DEPTH-1 drives output. Each stage: valid bit, address vector, addressValid vector.
- Reset (AsyncResetN=0, immediate): all valid bits 0, all data registers 0; occupancy 0, out_valid 0, out_addressValid 0, out_address 0, in_ready 0 while reset asserted.
- Output transfer: CE & out_valid & out_ready. Input transfer: CE & in_valid & in_ready.
- Advance rule (bubble collapse): last stage "moves" if empty or output transfer; stage k moves into k+1 when stage k+1 moves; stage k loads from k-1 (or from input for k=0) when stage k moves; an empty stage always accepts.
- in_ready = CE & !flush & (stage 0 empty or stage 0 moves); combinational from out_ready through the ripple chain; in_ready never depends on in_valid.
- Stage loaded with no source (upstream empty / no input transfer) becomes invalid; its data registers hold old contents.
- out_addressValid = stage DEPTH-1 addressValid AND out_valid; out_address is raw register contents.
- flush=1 and CE=1: next cycle all valid bits 0, occupancy 0; any concurrent input or output transfer is suppressed (out_ready ignored, in_ready 0). Data registers not cleared.
- CE=0: no state change; in_ready=0, out_valid=0 (bundle stays stored); flush ignored.
- occupancy = popcount of stage valids, registered state only.
- Bundle order preserved; no duplication, no drop except by flush.

## Timing
- Latency with out_ready=1 and empty pipe: bundle accepted at edge t appears on out at edge t+DEPTH-1 cycle later... precisely: captured into stage 0 at edge t, out_valid high after edge t+DEPTH-1 (DEPTH=1: visible right after the accepting edge).
- Full throughput: one bundle per cycle with out_ready=1 continuously.
- Full pipe (occupancy=DEPTH) and out_ready=0: in_ready=0. Full and out_ready=1: in_ready=1 same cycle (simultaneous push and pop; occupancy unchanged).
- Bubble: with out_ready=0, an accepted bundle advances through empty stages each cycle until it reaches the first occupied-stage tail.
- Async reset mid-transfer: all in-flight bundles lost; deassertion sampled synchronously, first transfer possible on the first edge after deassertion.

## Test plan
- Reset then DEPTH=2, NUM_ADDR=2, ADDR_WIDTH=8: push 0x11/0x22 valid 2'b01 with out_ready=1 -> out_valid at 2nd edge, out_address=0x2211, out_addressValid=2'b01, occupancy 1.
- Stream 8 bundles 0..7 back-to-back with out_ready=1 -> outputs 0..7 in order on consecutive cycles, in_ready constantly 1.
- out_ready=0, push 3 bundles into DEPTH=2 -> first two accepted, occupancy 2, in_ready 0 on third; raise out_ready -> third accepted same cycle as first popped.
- Fill to 2, assert flush with in_valid=1 and out_ready=1 -> no transfer, next cycle occupancy 0, out_valid 0, out_addressValid 0.
- CE=0 with occupancy 1 for 3 cycles -> out_valid 0, in_ready 0, occupancy 1 held; CE=1 -> stored bundle emerges unchanged.
- Assert AsyncResetN=0 between edges with occupancy 2 -> outputs 0 immediately without clock edge, occupancy 0.
